// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: one-entry holding register feeding an 8N1-style
// framer (start, PAYLOAD_BITS data LSB first, STOP_BITS stop) with registered txd.
module uart_tx_buffered #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_tx_en,
    input  logic                    uart_tx_valid,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_tx_ready,
    output logic                    uart_tx_busy,
    output logic                    uart_txd
);

    localparam int BIT_NS         = 1_000_000_000 / BIT_RATE;
    localparam int CLK_NS         = 1_000_000_000 / CLK_HZ;
    localparam int CYCLES_PER_BIT = BIT_NS / CLK_NS;
    localparam int CNT_W          = 1 + $clog2(CYCLES_PER_BIT);
    localparam int BIT_W          = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * CYCLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAYLOAD_BITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]              state;
    logic [CNT_W-1:0]        cycle_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [BIT_W-1:0]        next_bit;
    logic [PAYLOAD_BITS-1:0] hold_data;
    logic [PAYLOAD_BITS-1:0] shift_reg;
    logic [PAYLOAD_BITS-1:0] shifted;
    logic                    hold_full;
    logic                    txd_q;
    logic                    launch;

    // The frame word stays untouched for the whole frame; bits are picked by index.
    always_comb begin
        next_bit = bit_cnt + BIT_W'(1);
        shifted  = shift_reg >> next_bit;
        launch   = hold_full && uart_tx_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            shift_reg <= '0;
            txd_q     <= 1'b1;
        end else begin
            // Accept and launch never coincide: accept needs empty, launch needs full.
            if (uart_tx_valid && !hold_full) begin
                hold_data <= uart_tx_data;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    cycle_cnt <= '0;
                    bit_cnt   <= '0;
                    txd_q     <= 1'b1;
                    if (launch) begin
                        state     <= START;
                        shift_reg <= hold_data;
                        hold_full <= 1'b0;
                        txd_q     <= 1'b0;
                    end
                end

                START: begin
                    if (cycle_cnt == BIT_END) begin
                        cycle_cnt <= '0;
                        bit_cnt   <= '0;
                        state     <= DATA;
                        txd_q     <= shift_reg[0];
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cycle_cnt == BIT_END) begin
                        cycle_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                            txd_q <= 1'b1;
                        end else begin
                            bit_cnt <= next_bit;
                            txd_q   <= shifted[0];
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (cycle_cnt == STOP_END) begin
                        cycle_cnt <= '0;
                        bit_cnt   <= '0;
                        if (launch) begin
                            state     <= START;
                            shift_reg <= hold_data;
                            hold_full <= 1'b0;
                            txd_q     <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    txd_q <= 1'b1;
                end
            endcase
        end
    end

    assign uart_txd      = txd_q;
    assign uart_tx_ready = !hold_full;
    assign uart_tx_busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at 10 clocks per bit; expected frames are
// hand-written bit patterns (bit 0 = start bit, then data LSB first, then stop).
module tb_uart_tx_buffered;

    localparam int CPB = 10;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       sel2  = 1'b0;

    logic ready1, busy1, txd1;
    logic ready2, busy2, txd2;
    logic ready_s, busy_s, txd_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        ready_s = sel2 ? ready2 : ready1;
        busy_s  = sel2 ? busy2  : busy1;
        txd_s   = sel2 ? txd2   : txd1;
    end

    uart_tx_buffered #(
        .BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8), .STOP_BITS(1)
    ) dut1 (
        .clk(clk), .reset(reset), .uart_tx_en(en), .uart_tx_valid(valid),
        .uart_tx_data(data), .uart_tx_ready(ready1), .uart_tx_busy(busy1),
        .uart_txd(txd1)
    );

    uart_tx_buffered #(
        .BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8), .STOP_BITS(2)
    ) dut2 (
        .clk(clk), .reset(reset), .uart_tx_en(en), .uart_tx_valid(valid),
        .uart_tx_data(data), .uart_tx_ready(ready2), .uart_tx_busy(busy2),
        .uart_txd(txd2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; valid = 1'b0; en = 1'b1; data = 8'h00;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Returns 1 ns after edge E0, where the word has been captured.
    task automatic offer(input logic [7:0] d);
        @(posedge clk); #1;
        valid = 1'b1; data = d;
        @(posedge clk); #1;
    endtask

    task automatic check_accepted(input string name);
        @(negedge clk);
        check({name, "_ready_after_E0"}, {31'd0, ready_s}, 32'd0);
        check({name, "_busy_after_E0"},  {31'd0, busy_s},  32'd0);
        check({name, "_txd_after_E0"},   {31'd0, txd_s},   32'd1);
    endtask

    // Waits for the launching edge, then samples ncyc cycles against the
    // expected line: exp bits held CPB cycles each, idle-high afterwards.
    task automatic capture(input string name, input logic [31:0] exp, input int nbits,
                           input int ncyc, input int drop_valid_at, input int drop_en_at,
                           input bit toggle);
        int   bad_t = -1;
        int   bad_b = -1;
        logic got_t, got_b, et, eb, want_t, want_b;
        got_t = 1'b0; got_b = 1'b0; want_t = 1'b0; want_b = 1'b0;
        @(posedge clk);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (k == 0) check({name, "_ready_after_E1"}, {31'd0, ready_s}, 32'd1);
            et = (k < nbits * CPB) ? exp[k / CPB] : 1'b1;
            eb = (k < nbits * CPB);
            if (txd_s !== et && bad_t < 0) begin bad_t = k; got_t = txd_s; want_t = et; end
            if (busy_s !== eb && bad_b < 0) begin bad_b = k; got_b = busy_s; want_b = eb; end
            if (k == drop_valid_at) valid = 1'b0;
            if (k == drop_en_at) en = 1'b0;
            if (toggle) data = ~data;
        end
        checks++;
        if (bad_t >= 0) begin
            errors++;
            $display("FAIL %s_txd: cycle %0d got %b expected %b", name, bad_t, got_t, want_t);
        end
        checks++;
        if (bad_b >= 0) begin
            errors++;
            $display("FAIL %s_busy: cycle %0d got %b expected %b", name, bad_b, got_b, want_b);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   bad;
        vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
        vecs[1] = '{8'h00, 10'b1_0000_0000_0};
        vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
        vecs[3] = '{8'h01, 10'b1_0000_0001_0};
        vecs[4] = '{8'h80, 10'b1_1000_0000_0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txd1",   {31'd0, txd1},   32'd1);
        check("rst_busy1",  {31'd0, busy1},  32'd0);
        check("rst_ready1", {31'd0, ready1}, 32'd1);
        check("rst_txd2",   {31'd0, txd2},   32'd1);
        check("rst_busy2",  {31'd0, busy2},  32'd0);
        check("rst_ready2", {31'd0, ready2}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single frames from idle
        for (int i = 0; i < 5; i++) begin
            do_reset();
            offer(vecs[i].data);
            valid = 1'b0;
            check_accepted($sformatf("frame_%02h", vecs[i].data));
            capture($sformatf("frame_%02h", vecs[i].data), {22'd0, vecs[i].frame},
                    10, 105, -1, -1, 1'b0);
        end

        // Back-to-back: 0x0F accepted during the 0x55 frame, no idle gap
        do_reset();
        offer(8'h55);
        data = 8'h0F;
        check_accepted("b2b");
        capture("b2b", 32'b1_0000_1111_0_1_0101_0101_0, 20, 205, 1, -1, 1'b0);

        // Word offered while disabled waits, then sends when enabled
        do_reset();
        en = 1'b0;
        offer(8'h00);
        valid = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (txd_s !== 1'b1 || busy_s !== 1'b0 || ready_s !== 1'b0) bad++;
        end
        check("disabled_hold_cycles_bad", bad, 0);
        @(posedge clk); #1;
        en = 1'b1;
        capture("enable_late_00", {22'd0, 10'b1_0000_0000_0}, 10, 105, -1, -1, 1'b0);

        // Enable dropped mid-frame: current frame completes, pending word kept
        do_reset();
        offer(8'hC3);
        data = 8'h96;
        check_accepted("en_drop");
        capture("en_drop_first", {22'd0, 10'b1_1100_0011_0}, 10, 120, 1, 30, 1'b0);
        check("en_drop_pending_ready", {31'd0, ready_s}, 32'd0);
        @(posedge clk); #1;
        en = 1'b1;
        capture("en_drop_second", {22'd0, 10'b1_1001_0110_0}, 10, 105, -1, -1, 1'b0);

        // Reset mid-frame aborts frame and discards pending word
        do_reset();
        offer(8'hFF);
        data = 8'h12;
        check_accepted("mid_reset");
        @(posedge clk);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (k == 1) valid = 1'b0;
        end
        check("mid_reset_busy_before",  {31'd0, busy_s},  32'd1);
        check("mid_reset_ready_before", {31'd0, ready_s}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_txd",   {31'd0, txd_s},   32'd1);
        check("mid_reset_busy",  {31'd0, busy_s},  32'd0);
        check("mid_reset_ready", {31'd0, ready_s}, 32'd1);
        reset = 1'b0;
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (txd_s !== 1'b1 || busy_s !== 1'b0 || ready_s !== 1'b1) bad++;
        end
        check("mid_reset_quiet_cycles_bad", bad, 0);

        // Data input toggling during a frame is ignored
        do_reset();
        offer(8'h3C);
        valid = 1'b0;
        check_accepted("toggle_3C");
        capture("toggle_3C", {22'd0, 10'b1_0011_1100_0}, 10, 105, -1, -1, 1'b1);

        // Two stop bits
        do_reset();
        sel2 = 1'b1;
        offer(8'h81);
        valid = 1'b0;
        check_accepted("stop2_81");
        capture("stop2_81", {21'd0, 11'b11_1000_0001_0}, 11, 115, -1, -1, 1'b0);
        sel2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
